// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;
  localparam int MUL_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/and_32bit_bus.sv
// Fixed 32-bit bitwise AND bus, reused by the multiplier to form partial products.
module and_32bit_bus (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a & b;
endmodule

// File: rtl/shift_add_mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with valid/ready handshakes.
// Optional early termination when SHIFT_ADD_MUL_EARLY_TERM_EN is defined.
module shift_add_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  mul_state_t               state_r;
  mul_state_t               state_s;
  logic [WIDTH-1:0]         m_r;
  // Bit 64 of the accumulator is always zero after the shift, so it is not stored.
  logic [2*WIDTH-1:0]       p_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [2*WIDTH-1:0]       product_r;
  logic [WIDTH-1:0]         pp_s;
  logic [WIDTH:0]           sum_s;
  logic [2*WIDTH-1:0]       p_step_s;
  logic [2*WIDTH-1:0]       p_final_s;
  logic                     load_s;
  logic                     step_s;
  logic                     last_s;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  logic [WIDTH-2:0]         mr_r;
  logic [CNT_W-1:0]         shamt_s;
`endif

  and_32bit_bus u_and_bus (
    .a (m_r),
    .b ({WIDTH{p_r[0]}}),
    .y (pp_s)
  );

  // Datapath: one accumulate-and-shift step, plus the collapsed tail shift.
  always_comb begin
    sum_s    = {1'b0, p_r[2*WIDTH-1:WIDTH]} + {1'b0, pp_s};
    p_step_s = {sum_s, p_r[WIDTH-1:1]};
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    shamt_s   = CNT_W'(MUL_STEPS - 1) - cnt_r;
    p_final_s = p_step_s >> shamt_s;
    last_s    = (cnt_r == CNT_W'(MUL_STEPS - 1)) || (mr_r == {(WIDTH-1){1'b0}});
`else
    p_final_s = p_step_s;
    last_s    = (cnt_r == CNT_W'(MUL_STEPS - 1));
`endif
  end

  // Next-state and control strobes.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, accumulator, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r       <= {WIDTH{1'b0}};
      p_r       <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
      mr_r      <= {(WIDTH-1){1'b0}};
`endif
    end else if (load_s) begin
      m_r   <= multiplicand;
      p_r   <= {{WIDTH{1'b0}}, multiplier};
      cnt_r <= {CNT_W{1'b0}};
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
      mr_r  <= multiplier[WIDTH-1:1];
`endif
    end else if (step_s) begin
      p_r   <= p_step_s;
      cnt_r <= cnt_r + CNT_W'(1);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
      mr_r  <= mr_r >> 1;
`endif
      if (last_s) begin
        product_r <= p_final_s;
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign out_valid = (state_r == DONE);
  assign product   = product_r;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Randomized self-checking bench for shift_add_mul_seq against a plain-multiply reference.
module tb_shift_add_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] multiplicand = 32'd0;
  logic [31:0] multiplier = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] product;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] last_prod = 64'd0;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  always #5 clk = ~clk;

  shift_add_mul_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Early-terminated latency: one cycle per step up to the highest set bit (at least one), plus DONE.
  function automatic int et_latency(input logic [31:0] b);
    int steps = 1;
    for (int i = 0; i < 32; i++) if (b[i]) steps = i + 1;
    return steps + 1;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    logic [63:0] exp_p;
    int          want;
    int          lat;
    bit          ctl_bad;
    bit          hold_bad;
    exp_p    = {32'd0, a} * {32'd0, b};
    want     = EARLY_TERM ? et_latency(b) : 33;
    lat      = 0;
    ctl_bad  = 1'b0;
    hold_bad = 1'b0;
    check_eq({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    out_ready    = (hold == 0);
    do begin
      @(negedge clk);
      lat++;
      multiplicand = $urandom;
      multiplier   = $urandom;
      if (!out_valid && (in_ready || !busy)) ctl_bad = 1'b1;
      if (!out_valid && (product !== last_prod)) ctl_bad = 1'b1;
    end while (!out_valid && lat < 200);
    check_eq({tag, "_latency"}, 64'(lat), 64'(want));
    check_eq({tag, "_product"}, product, exp_p);
    check_eq({tag, "_run_ctl"}, {63'd0, ctl_bad}, 64'd0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        multiplicand = $urandom;
        multiplier   = $urandom;
        if (!out_valid || in_ready || !busy || (product !== exp_p)) hold_bad = 1'b1;
      end
      check_eq({tag, "_hold"}, {63'd0, hold_bad}, 64'd0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_after_hs"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    check_eq({tag, "_prod_kept"}, product, exp_p);
    start     = 1'b0;
    out_ready = 1'b0;
    last_prod = exp_p;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check_eq("reset_product", product, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd7, 32'd6, 0, "mul_7x6");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
    run_op(32'h0001_0000, 32'h0001_0000, 5, "mul_hold");

    // Reset in the middle of RUN drops the operation.
    start        = 1'b1;
    multiplicand = 32'h0000_AAAA;
    multiplier   = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_reset_busy", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_reset_ctl", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check_eq("async_reset_product", product, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_prod = 64'd0;
    @(negedge clk);
    run_op(32'd3, 32'd5, 0, "mul_3x5");

    run_op(32'hDEAD_BEEF, 32'd2, 0, "b2b_first");
    run_op(32'd0, 32'h1234_5678, 0, "b2b_second");
    run_op(32'h1234_5678, 32'd3, 1, "mul_x3");
    run_op(32'hCAFE_F00D, 32'd0, 0, "mul_by0");
    run_op(32'h9ABC_DEF1, 32'h8000_0000, 2, "mul_msb");

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if ((i % 3) == 1) rb = rb >> $urandom_range(31, 0);
      run_op(ra, rb, $urandom_range(3, 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
